if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised fetch-side instruction queue that sits between the I-cache fetch response and decode. It replaces the fixed two-instruction, two-cycle partial-fetch handling with halfword-granular realignment of any FETCH_WIDTH line. It reassembles 32-bit instructions that straddle fetches, drops instructions after a predicted-taken branch, and buffers up to DEPTH instructions. Decode receives up to OUT_LANES instructions per cycle under a valid/ready handshake.

Parameters:
PC_BITS, 32, PC width
INSTR_BITS, 32, instruction width; fixed at 2 halfwords
FETCH_WIDTH, 64, fetch line width; multiple of INSTR_BITS; FETCH_SLOTS=FETCH_WIDTH/INSTR_BITS, HW=FETCH_WIDTH/16
OUT_LANES, 2, instructions presented to decode per cycle
DEPTH, 8, queue entries; power of 2, >= FETCH_SLOTS+OUT_LANES

Ports:
clk  in  1  clock
rst_n  in  1  reset
flush_i  in  1  discard queue contents and pending fragment
in_valid_i  in  1  fetch response valid
in_ready_o  out  1  queue can accept a full fetch
in_pc_i  in  PC_BITS  PC of halfword 0 of in_data_i
in_data_i  in  FETCH_WIDTH  fetched halfwords, halfword 0 in bits [15:0]
in_hw_count_i  in  $clog2(HW)+1  valid halfwords from the low end, 0..HW
in_taken_i  in  HW  bit k = instruction ending at halfword k is predicted taken
out_valid_o  out  OUT_LANES  lane i holds an instruction; thermometer-coded
out_ready_i  in  1  decode consumes all valid lanes
out_pc_o  out  OUT_LANES*PC_BITS  lane PCs, lane 0 in the low bits
out_data_o  out  OUT_LANES*INSTR_BITS  lane instructions
out_taken_o  out  OUT_LANES  lane predicted-taken flag
count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset is rst_n: asynchronous, active-low. Clock is clk. Reset clears count, head/tail pointers, frag_valid and all outputs to 0. in_ready_o is 1 after reset.
- Entry content: {pc, instr, taken}. Storage is a circular buffer, and pointers wrap modulo DEPTH.
- in_ready_o = (DEPTH - count) >= FETCH_SLOTS. It is derived from registered count only and does not depend on the current pop.
- A fetch is accepted when in_valid_i && in_ready_o && !flush_i.
- Fragment register holds {frag_valid, frag_pc, frag_hw}.
- Fragment continuity: on accept with frag_valid, if in_pc_i != frag_pc+2, drop the fragment and treat the fetch as if no fragment were held.
- Halfword stream per accepted fetch = optional frag_hw followed by halfwords 0..in_hw_count_i-1. Pair them in order into instructions. Instruction j takes pc = frag_pc (if a fragment was used) else in_pc_i + 4j, adjusted by +2 offsets consistently. Its high halfword is the later one.
- Taken flag = in_taken_i[k], where k is the fetch-halfword index of the instruction's upper halfword.
- The first taken instruction is the last one written. Later halfwords are discarded and no new fragment is saved.
- If no taken instruction was found and the stream length is odd, the last halfword becomes the new fragment: frag_pc = its PC, frag_valid = 1. Otherwise frag_valid = 0.
- in_hw_count_i = 0 with a held fragment leaves the fragment unchanged and writes nothing.
- Up to FETCH_SLOTS instructions are written per accept, at tail, in order.
- Output lanes: out_valid_o[i] = (count > i). Lane i shows entry head+i.
- Pop happens when out_ready_i=1 and out_valid_o[0]=1. It removes popcount(out_valid_o) entries.
- Push and pop in the same cycle: count = count + pushed - popped.
- flush_i has the highest priority. Next cycle count=0, frag_valid=0, and the push and pop in the flush cycle are ignored. Outputs are invalid the cycle after flush.
- Latency: an accepted instruction is visible at the output the cycle after acceptance.

Optional Feature:
IFQ_BYPASS_EN: when count==0, out_ready_i=1 and no flush, the realigned instructions of the current accept drive the lanes combinationally in the same cycle. Consumed lanes are not written into the queue, and any remainder is enqueued. Without the macro, no bypass exists and latency is 1 cycle.

Test Plan:
1. FETCH_WIDTH=64, in_pc=0x100, hw_count=4, taken=0, out_ready=1 -> next cycle lanes {0x100,0x104} valid, count=0 after pop.
2. Fetch pc=0x200, hw_count=3 (data hw0..2 = A,B,C), then fetch pc=0x206, hw_count=4 (D,E,F,G) -> instructions 0x200={B,A}, 0x204={D,C}, 0x208={F,E}; fragment G held, frag_pc=0x20C.
3. Fragment held at frag_pc=0x20C, next fetch pc=0x300 -> fragment dropped, 0x300 starts at its halfword 0.
4. pc=0x400, hw_count=4, in_taken=4'b0010 -> only 0x400 enqueued with taken=1, frag_valid=0.
5. out_ready=0, push until count=7 with DEPTH=8 -> in_ready_o=0. Then flush_i with in_valid=1 -> count=0, in_ready_o=1, out_valid_o=0.
6. Apply rst_n low for 1 cycle mid-stream with count=5 and a fragment held -> count_o=0, out_valid_o=0, frag cleared, in_ready_o=1 asynchronously.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: the fetch-side instruction queue between the I-cache fetch
// response and decode.
//
// Each accepted fetch line is realigned at halfword granularity. A 32-bit
// instruction that straddles two fetches is rebuilt from a held fragment. The
// stream is cut after the first predicted-taken instruction. Up to DEPTH
// instructions are buffered, and up to OUT_LANES of them are presented to
// decode each cycle.
//
// Optional build macro: IFQ_BYPASS_EN. When it is defined and the queue is
// empty, the instructions realigned from the current fetch drive the decode
// lanes in the same cycle. Without the macro the queue adds exactly one cycle
// of latency.
//
// Handshake semantics:
//   Fetch side  - a line is taken on a clk edge where in_valid_i && in_ready_o
//                 && !flush_i. in_ready_o depends only on registered occupancy,
//                 so it can never combinationally follow in_valid_i or
//                 out_ready_i.
//   Decode side - out_valid_o is thermometer coded. When out_ready_i is high
//                 and lane 0 is valid, every valid lane is consumed on that
//                 edge.
//   flush_i overrides both sides: nothing is pushed or popped in that cycle.
module if_fetch_queue #(
  parameter int PC_BITS     = 32,
  parameter int INSTR_BITS  = 32,
  parameter int FETCH_WIDTH = 64,
  parameter int OUT_LANES   = 2,
  parameter int DEPTH       = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [PC_BITS-1:0]               in_pc_i,
  input  logic [FETCH_WIDTH-1:0]           in_data_i,
  input  logic [$clog2(FETCH_WIDTH/16):0]  in_hw_count_i,
  input  logic [FETCH_WIDTH/16-1:0]        in_taken_i,
  output logic [OUT_LANES-1:0]             out_valid_o,
  input  logic                             out_ready_i,
  output logic [OUT_LANES*PC_BITS-1:0]     out_pc_o,
  output logic [OUT_LANES*INSTR_BITS-1:0]  out_data_o,
  output logic [OUT_LANES-1:0]             out_taken_o,
  output logic [$clog2(DEPTH):0]           count_o
);

  localparam int FETCH_SLOTS = FETCH_WIDTH / INSTR_BITS;
  localparam int HW          = FETCH_WIDTH / 16;
  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = $clog2(DEPTH) + 1;
  localparam int SLOT_W      = $clog2(FETCH_SLOTS + 1);
  localparam int SW          = $clog2(HW + 2);

  // Queue storage: one {pc, instr, taken} entry per slot.
  logic [PC_BITS-1:0]    mem_pc    [DEPTH];
  logic [INSTR_BITS-1:0] mem_instr [DEPTH];
  logic [DEPTH-1:0]      mem_taken;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // Trailing halfword of a fetch whose partner has not arrived yet.
  logic               frag_valid;
  logic [PC_BITS-1:0] frag_pc;
  logic [15:0]        frag_hw;

  // Realignment results for the current fetch.
  logic                  accept;
  logic                  use_frag;
  logic [PC_BITS-1:0]    base_pc;
  logic [15:0]           strm [HW+1];
  logic [SW-1:0]         strm_len;
  logic [PC_BITS-1:0]    ins_pc    [FETCH_SLOTS];
  logic [INSTR_BITS-1:0] ins_data  [FETCH_SLOTS];
  logic [FETCH_SLOTS-1:0] ins_taken;
  logic [SLOT_W-1:0]     n_ins;
  logic                  hit_taken;
  logic                  nxt_frag_valid;
  logic [PC_BITS-1:0]    nxt_frag_pc;
  logic [15:0]           nxt_frag_hw;

  // Bookkeeping for pushes and pops.
  logic [SLOT_W-1:0] n_byp;
  logic [SLOT_W-1:0] n_push;
  logic [CNT_W-1:0]  n_pop;

  assign in_ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_SLOTS);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign count_o    = count;

  // Build the halfword stream (fragment first if continuous), then pair it into
  // instructions. The stream stops at and includes the first taken one.
  always_comb begin
    use_frag = frag_valid && (in_pc_i == frag_pc + PC_BITS'(2));
    base_pc  = use_frag ? frag_pc : in_pc_i;
    for (int s = 0; s <= HW; s++) strm[s] = '0;
    if (use_frag) begin
      strm[0] = frag_hw;
      for (int s = 0; s < HW; s++) strm[s+1] = in_data_i[16*s +: 16];
    end else begin
      for (int s = 0; s < HW; s++) strm[s] = in_data_i[16*s +: 16];
    end
    strm_len = SW'(in_hw_count_i) + SW'(use_frag);

    n_ins     = '0;
    hit_taken = 1'b0;
    ins_taken = '0;
    for (int j = 0; j < FETCH_SLOTS; j++) begin
      ins_pc[j]   = base_pc + PC_BITS'(4 * j);
      ins_data[j] = {strm[2*j+1], strm[2*j]};
      // With a fragment in front, the upper halfword of instruction j is
      // fetch halfword 2j; otherwise it is fetch halfword 2j+1.
      ins_taken[j] = use_frag ? in_taken_i[2*j] : in_taken_i[2*j+1];
      if (!hit_taken && (SW'(2*j+1) < strm_len)) begin
        n_ins     = SLOT_W'(j + 1);
        hit_taken = ins_taken[j];
      end
    end

    // An odd leftover halfword waits for its partner, unless the stream was
    // cut by a taken branch.
    nxt_frag_valid = 1'b0;
    nxt_frag_pc    = frag_pc;
    nxt_frag_hw    = frag_hw;
    if (!hit_taken && strm_len[0]) begin
      nxt_frag_valid = 1'b1;
      nxt_frag_pc    = base_pc + PC_BITS'({n_ins, 2'b00});
      for (int s = 0; s <= HW; s++) begin
        if (SW'(s) == strm_len - SW'(1)) nxt_frag_hw = strm[s];
      end
    end
  end

`ifdef IFQ_BYPASS_EN
  logic byp_active;
  assign byp_active = accept && (count == '0) && out_ready_i;

  // While the queue is empty, decode takes realigned instructions directly.
  always_comb begin
    n_byp = '0;
    if (byp_active) begin
      if (int'(n_ins) > OUT_LANES) n_byp = SLOT_W'(OUT_LANES);
      else                         n_byp = n_ins;
    end
  end
`else
  assign n_byp = '0;
`endif

  assign n_push = accept ? (n_ins - n_byp) : '0;

  // Queue pops take every valid lane; the bypassed lanes never enter the queue.
  always_comb begin
    n_pop = '0;
    if (out_ready_i && (count != '0)) begin
      if (count > CNT_W'(OUT_LANES)) n_pop = CNT_W'(OUT_LANES);
      else                           n_pop = count;
    end
  end

  // Present lanes head..head+OUT_LANES-1. Invalid lanes are forced to zero.
  always_comb begin
    out_valid_o = '0;
    out_pc_o    = '0;
    out_data_o  = '0;
    out_taken_o = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      if (count > CNT_W'(i)) begin
        out_valid_o[i]                         = 1'b1;
        out_pc_o[i*PC_BITS +: PC_BITS]         = mem_pc[head + PTR_W'(i)];
        out_data_o[i*INSTR_BITS +: INSTR_BITS] = mem_instr[head + PTR_W'(i)];
        out_taken_o[i]                         = mem_taken[head + PTR_W'(i)];
      end
    end
`ifdef IFQ_BYPASS_EN
    if (byp_active) begin
      for (int i = 0; i < OUT_LANES && i < FETCH_SLOTS; i++) begin
        if (SLOT_W'(i) < n_byp) begin
          out_valid_o[i]                         = 1'b1;
          out_pc_o[i*PC_BITS +: PC_BITS]         = ins_pc[i];
          out_data_o[i*INSTR_BITS +: INSTR_BITS] = ins_data[i];
          out_taken_o[i]                         = ins_taken[i];
        end
      end
    end
`endif
  end

  // Occupancy, pointers and fragment register. A flush resets them and wins
  // over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      frag_valid <= 1'b0;
      frag_pc    <= '0;
      frag_hw    <= '0;
    end else if (flush_i) begin
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      frag_valid <= 1'b0;
    end else begin
      count <= count + CNT_W'(n_push) - n_pop;
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      // An empty fetch leaves a held fragment untouched.
      if (accept && (in_hw_count_i != '0)) begin
        frag_valid <= nxt_frag_valid;
        frag_pc    <= nxt_frag_pc;
        frag_hw    <= nxt_frag_hw;
      end
    end
  end

  // Write the non-bypassed instructions of an accepted fetch at tail, in order.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < FETCH_SLOTS; j++) begin
        if ((SLOT_W'(j) >= n_byp) && (SLOT_W'(j) < n_ins)) begin
          mem_pc[tail + PTR_W'(j) - PTR_W'(n_byp)]    <= ins_pc[j];
          mem_instr[tail + PTR_W'(j) - PTR_W'(n_byp)] <= ins_data[j];
          mem_taken[tail + PTR_W'(j) - PTR_W'(n_byp)] <= ins_taken[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue (default build, no bypass).
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic [63:0] in_data_i;
  logic [2:0]  in_hw_count_i;
  logic [3:0]  in_taken_i;
  logic [1:0]  out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_pc_o;
  logic [63:0] out_data_o;
  logic [1:0]  out_taken_o;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] l0_pc, l1_pc, l0_data, l1_data;
  assign l0_pc   = out_pc_o[31:0];
  assign l1_pc   = out_pc_o[63:32];
  assign l0_data = out_data_o[31:0];
  assign l1_data = out_data_o[63:32];

  if_fetch_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_pc_i      (in_pc_i),
    .in_data_i    (in_data_i),
    .in_hw_count_i(in_hw_count_i),
    .in_taken_i   (in_taken_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_pc_o     (out_pc_o),
    .out_data_o   (out_data_o),
    .out_taken_o  (out_taken_o),
    .count_o      (count_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one fetch line for one clock edge, then return 1 time unit after it.
  task automatic fetch(input logic [31:0] pc, input logic [63:0] data,
                       input logic [2:0] cnt, input logic [3:0] taken);
    in_valid_i    = 1'b1;
    in_pc_i       = pc;
    in_data_i     = data;
    in_hw_count_i = cnt;
    in_taken_i    = taken;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_taken_i = '0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_pc_i = '0;
    in_data_i = '0; in_hw_count_i = '0; in_taken_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_pc", out_pc_o, 0);
    rst_n = 1'b1;
    idle_cycle();

    // 1: full aligned line, decode ready
    out_ready_i = 1'b1;
    fetch(32'h100, 64'h4444_3333_2222_1111, 3'd4, 4'b0000);
    check("t1_valid", out_valid_o, 2'b11);
    check("t1_pc0", l0_pc, 32'h100);
    check("t1_pc1", l1_pc, 32'h104);
    check("t1_d0", l0_data, 32'h2222_1111);
    check("t1_d1", l1_data, 32'h4444_3333);
    idle_cycle();
    check("t1_count_after_pop", count_o, 0);
    check("t1_valid_after_pop", out_valid_o, 0);

    // 2: straddling instructions across two fetches
    out_ready_i = 1'b0;
    fetch(32'h200, 64'h9999_CCCC_BBBB_AAAA, 3'd3, 4'b0000);
    check("t2a_count", count_o, 1);
    check("t2a_pc0", l0_pc, 32'h200);
    check("t2a_d0", l0_data, 32'hBBBB_AAAA);
    fetch(32'h206, 64'h1234_FFFF_EEEE_DDDD, 3'd4, 4'b0000);
    check("t2b_count", count_o, 3);
    check("t2b_pc1", l1_pc, 32'h204);
    check("t2b_d1", l1_data, 32'hDDDD_CCCC);
    out_ready_i = 1'b1;
    idle_cycle();
    out_ready_i = 1'b0;
    check("t2c_count", count_o, 1);
    check("t2c_pc0", l0_pc, 32'h208);
    check("t2c_d0", l0_data, 32'hFFFF_EEEE);
    // Completes the held fragment at 0x20C while 0x208 is popped.
    out_ready_i = 1'b1;
    fetch(32'h20E, 64'h0000_0000_0000_7777, 3'd1, 4'b0000);
    check("t2d_count", count_o, 1);
    check("t2d_pc0", l0_pc, 32'h20C);
    check("t2d_d0", l0_data, 32'h7777_1234);

    // Zero-halfword fetch keeps a fragment
    fetch(32'h280, 64'h0000_0000_0000_5555, 3'd1, 4'b0000);
    check("t3a_count", count_o, 0);
    fetch(32'h998, 64'h0, 3'd0, 4'b0000);
    check("t3b_count", count_o, 0);
    fetch(32'h282, 64'h0000_0000_0000_6666, 3'd1, 4'b0000);
    check("t3c_pc0", l0_pc, 32'h280);
    check("t3c_d0", l0_data, 32'h6666_5555);

    // 3: discontinuous fetch drops the fragment
    fetch(32'h290, 64'h0000_0000_0000_7070, 3'd1, 4'b0000);
    fetch(32'h300, 64'h0000_0000_2300_1300, 3'd2, 4'b0000);
    check("t3d_count", count_o, 1);
    check("t3d_pc0", l0_pc, 32'h300);
    check("t3d_d0", l0_data, 32'h2300_1300);

    // 4: taken branch truncates the line and leaves no fragment
    fetch(32'h400, 64'h3400_2400_1400_0400, 3'd4, 4'b0010);
    check("t4_valid", out_valid_o, 2'b01);
    check("t4_pc0", l0_pc, 32'h400);
    check("t4_d0", l0_data, 32'h1400_0400);
    check("t4_taken", out_taken_o, 2'b01);
    fetch(32'h406, 64'h0000_0000_BB06_AA06, 3'd2, 4'b0000);
    check("t4b_pc0", l0_pc, 32'h406);
    check("t4b_d0", l0_data, 32'hBB06_AA06);
    check("t4b_taken", out_taken_o, 2'b00);

    // Taken on an instruction completed by a fragment (upper half is fetch hw0)
    fetch(32'h500, 64'h0000_0000_0000_0500, 3'd1, 4'b0000);
    fetch(32'h502, 64'h3502_2502_1502_0502, 3'd4, 4'b0001);
    check("t4c_valid", out_valid_o, 2'b01);
    check("t4c_pc0", l0_pc, 32'h500);
    check("t4c_d0", l0_data, 32'h0502_0500);
    check("t4c_taken", out_taken_o, 2'b01);
    idle_cycle();
    check("t4c_drained", count_o, 0);

    // 5: fill to 7, backpressure, then flush
    out_ready_i = 1'b0;
    fetch(32'h700, 64'h0, 3'd4, 4'b0000);
    fetch(32'h708, 64'h0, 3'd4, 4'b0000);
    fetch(32'h710, 64'h0, 3'd4, 4'b0000);
    check("t5_count6", count_o, 6);
    check("t5_ready6", in_ready_o, 1);
    fetch(32'h718, 64'h0, 3'd2, 4'b0000);
    check("t5_count7", count_o, 7);
    check("t5_ready7", in_ready_o, 0);
    check("t5_valid7", out_valid_o, 2'b11);
    check("t5_pc0", l0_pc, 32'h700);
    fetch(32'h720, 64'h0, 3'd4, 4'b0000);
    check("t5_blocked", count_o, 7);
    flush_i = 1'b1; in_valid_i = 1'b1; out_ready_i = 1'b1;
    in_hw_count_i = 3'd4;
    idle_cycle();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("t5_flush_count", count_o, 0);
    check("t5_flush_ready", in_ready_o, 1);
    check("t5_flush_valid", out_valid_o, 0);
    fetch(32'h800, 64'h0000_0000_0800_0801, 3'd2, 4'b0000);
    check("t5_post_count", count_o, 1);
    check("t5_post_pc0", l0_pc, 32'h800);
    out_ready_i = 1'b1;
    idle_cycle();

    // 6: asynchronous reset mid-stream with a fragment held
    out_ready_i = 1'b0;
    fetch(32'h600, 64'h0, 3'd4, 4'b0000);
    fetch(32'h608, 64'h0, 3'd4, 4'b0000);
    fetch(32'h610, 64'h0000_CC10_BB10_AA10, 3'd3, 4'b0000);
    check("t6_count5", count_o, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", count_o, 0);
    check("t6_rst_valid", out_valid_o, 0);
    check("t6_rst_ready", in_ready_o, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    fetch(32'h616, 64'h0000_0000_1616_0616, 3'd2, 4'b0000);
    check("t6_nofrag_pc", l0_pc, 32'h616);
    check("t6_nofrag_d", l0_data, 32'h1616_0616);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
